ioctl_rom_router: RTL
=====================

Name: ioctl_rom_router

Overview:
- Parametrised successor to the fixed per-ROM download selector: one instance routes MiSTer ioctl ROM-download bytes for a single ioctl_index into NUM_REGIONS equal-size ROM regions.
- Produces registered one-hot write enables, region-local address and data, and per-region load tracking.
- Holds the core in reset until a complete, in-range download has finished.
- One instance per board: CPU board at index 0, sound board at index 1.

Parameters:
NUM_REGIONS, 15, number of ROM regions (1..32)
REGION_AW, 12, log2 region size in bytes (4 KB default)
INDEX, 0, ioctl_index value this instance accepts

Ports:
clk_49m  in  1  system clock (49.152 MHz)
reset  in  1  asynchronous, active-high reset
ioctl_download  in  1  HPS download-active strobe
ioctl_index  in  8  download target index
ioctl_addr  in  25  download byte address
ioctl_data  in  8  download byte
ioctl_wr  in  1  download byte strobe, one cycle per byte
region_we  out  NUM_REGIONS  one-hot write enable to region ROMs
region_addr  out  REGION_AW  region-local byte address
region_data  out  8  byte to write
region_loaded  out  NUM_REGIONS  per-region "last byte written" flags
load_done  out  1  download complete, all regions loaded
core_hold  out  1  hold the core in reset while not ready
oob_error  out  1  sticky: write beyond NUM_REGIONS<<REGION_AW seen
byte_count  out  25  accepted in-range writes this download

Behaviour:
- Reset (asynchronous, active-high): state IDLE; region_we=0, region_addr=0, region_data=0, region_loaded=0, load_done=0, core_hold=1, oob_error=0, byte_count=0.
- sel = (ioctl_index==INDEX). dl_q = registered ioctl_download. rise = ioctl_download & ~dl_q & sel. fall = ~ioctl_download & dl_q.
- States:
  - IDLE: rise -> LOADING.
  - LOADING: fall -> FLUSH.
  - FLUSH: one cycle -> DONE if &region_loaded and ~oob_error, else FAIL.
  - DONE: rise -> LOADING.
  - FAIL: rise -> LOADING.
- Entering LOADING (on rise) clears region_loaded, oob_error, byte_count and load_done in the same edge.
- Accept condition: state==LOADING & ioctl_wr & sel. A write in the same cycle as rise is dropped (the state is still not LOADING). A write in the same cycle as fall is accepted.
- Region index n = ioctl_addr[REGION_AW+4:REGION_AW]. In range iff ioctl_addr < NUM_REGIONS<<REGION_AW.
- In-range accept, 1-cycle latency:
  - region_we = 1<<n for exactly one cycle; region_addr = ioctl_addr[REGION_AW-1:0]; region_data = ioctl_data.
  - byte_count += 1.
  - If the local address is all-ones, region_loaded[n] is set.
- Out-of-range accept: region_we stays 0; oob_error is set and stays set until the next rise; byte_count is unchanged.
- With no accept, region_we=0 on the next cycle. region_addr and region_data hold their last values.
- byte_count saturates at 2^25-1 and never wraps.
- Outputs per state: core_hold=0 only in DONE; load_done=1 only in DONE.
- Writes in the FLUSH cycle are ignored.
- ioctl_download edges for other indices do not change state, but dl_q tracks them. A fall is honoured regardless of index.
- Asynchronous reset mid-download returns to IDLE with all flags cleared. Bytes already written stay in the ROMs.

Optional Feature:
- Macro ROUTER_CHECKSUM_EN.
- When defined:
  - Adds output checksum (16 bits): a modulo-2^16 sum of all in-range accepted bytes.
  - Cleared on reset and on rise; updated with the same 1-cycle latency as region_we.
  - Valid from DONE or FAIL onward.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. INDEX=0, NUM_REGIONS=2, REGION_AW=4. rise; bytes 0x00..0x1F at addrs 0..31; fall -> region_we pulses 01 x16 then 10 x16; region_loaded=2'b11; byte_count=32; after FLUSH load_done=1, core_hold=0.
2. Same, addr 0x25 written with 0xAA -> region_we stays 0; oob_error=1; final state FAIL (core_hold=1, load_done=0). Next rise clears oob_error.
3. Download covering only addrs 0..15; fall -> region_loaded=01; FAIL; core_hold=1.
4. ioctl_index=1, rise, writes to addrs 0..31 -> no region_we, state stays IDLE, byte_count=0.
5. Assert reset mid-LOADING after 10 bytes -> all outputs at reset values within the same cycle. Subsequent full download -> DONE.
6. (ROUTER_CHECKSUM_EN) Scenario 1 data -> checksum = 0x01F0 (sum 0..31 = 496).

Source files
------------

// File: rtl/ioctl_rom_router.sv
// Routes ioctl ROM-download bytes for one ioctl_index into equal-size regions.
// Optional ROUTER_CHECKSUM_EN adds a 16-bit sum of accepted bytes.
module ioctl_rom_router #(
  parameter int         NUM_REGIONS = 15,
  parameter int         REGION_AW   = 12,
  parameter logic [7:0] INDEX       = 8'd0
) (
  input  logic                   clk_49m,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic [7:0]             ioctl_index,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_data,
  input  logic                   ioctl_wr,
  output logic [NUM_REGIONS-1:0] region_we,
  output logic [REGION_AW-1:0]   region_addr,
  output logic [7:0]             region_data,
  output logic [NUM_REGIONS-1:0] region_loaded,
  output logic                   load_done,
  output logic                   core_hold,
  output logic                   oob_error,
  output logic [24:0]            byte_count
`ifdef ROUTER_CHECKSUM_EN
  ,
  output logic [15:0]            checksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADING,
    S_FLUSH,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [25:0] LIMIT = 26'(NUM_REGIONS) << REGION_AW;

  state_t                 state;
  logic                   dl_q;
  logic                   sel;
  logic                   rise;
  logic                   fall;
  logic                   acc;
  logic                   in_rng;
  logic                   lo_ones;
  logic [4:0]             n;
  logic [NUM_REGIONS-1:0] hot;

  always_comb begin
    sel     = (ioctl_index == INDEX);
    rise    = ioctl_download & ~dl_q & sel;
    fall    = ~ioctl_download & dl_q;
    acc     = (state == S_LOADING) & ioctl_wr & sel;
    in_rng  = ({1'b0, ioctl_addr} < LIMIT);
    lo_ones = &ioctl_addr[REGION_AW-1:0];
    n       = ioctl_addr[REGION_AW+4:REGION_AW];
    hot     = '0;
    for (int i = 0; i < NUM_REGIONS; i++)
      hot[i] = (n == 5'(i));
  end

  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      dl_q          <= 1'b0;
      region_we     <= '0;
      region_addr   <= '0;
      region_data   <= '0;
      region_loaded <= '0;
      load_done     <= 1'b0;
      core_hold     <= 1'b1;
      oob_error     <= 1'b0;
      byte_count    <= '0;
`ifdef ROUTER_CHECKSUM_EN
      checksum      <= '0;
`endif
    end else begin
      dl_q      <= ioctl_download;
      region_we <= '0;
      if (acc && in_rng) begin
        region_we   <= hot;
        region_addr <= ioctl_addr[REGION_AW-1:0];
        region_data <= ioctl_data;
        if (byte_count != '1)
          byte_count <= byte_count + 25'd1;
        if (lo_ones)
          region_loaded <= region_loaded | hot;
`ifdef ROUTER_CHECKSUM_EN
        checksum <= checksum + 16'(ioctl_data);
`endif
      end
      if (acc && !in_rng)
        oob_error <= 1'b1;
      // rise is only acted on outside LOADING, so it never races an accept
      unique case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (rise) begin
            state         <= S_LOADING;
            region_loaded <= '0;
            oob_error     <= 1'b0;
            byte_count    <= '0;
            load_done     <= 1'b0;
            core_hold     <= 1'b1;
`ifdef ROUTER_CHECKSUM_EN
            checksum      <= '0;
`endif
          end
        end
        S_LOADING: begin
          if (fall)
            state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (&region_loaded && !oob_error) begin
            state     <= S_DONE;
            load_done <= 1'b1;
            core_hold <= 1'b0;
          end else begin
            state <= S_FAIL;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
